// File: rtl/nv_nvdla_grp_single_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : nv_nvdla_grp_single_reg_if
// Description : CSB-side register access bus for the group single-register
//               block. The master drives offset/data/strobes, the slave
//               returns registered read data with a one-cycle valid strobe.
//   reg_offset   12  byte offset of the access
//   reg_wr_data  32  write data
//   reg_wr_en     1  write strobe, one cycle per write
//   reg_rd_en     1  read strobe, one cycle per read
//   reg_rd_data  32  read data, valid with reg_rd_vld
//   reg_rd_vld    1  read data valid, one cycle after reg_rd_en
// Revision    : 1.0 - initial release
// ============================================================================
interface nv_nvdla_grp_single_reg_if;
   logic [11:0] reg_offset;
   logic [31:0] reg_wr_data;
   logic        reg_wr_en;
   logic        reg_rd_en;
   logic [31:0] reg_rd_data;
   logic        reg_rd_vld;

   modport master (
      output reg_offset, reg_wr_data, reg_wr_en, reg_rd_en,
      input  reg_rd_data, reg_rd_vld
   );

   modport slave (
      input  reg_offset, reg_wr_data, reg_wr_en, reg_rd_en,
      output reg_rd_data, reg_rd_vld
   );
endinterface
`default_nettype wire

// File: rtl/nv_nvdla_grp_single_reg.sv
`default_nettype none
// ============================================================================
// Module      : nv_nvdla_grp_single_reg
// Description : Single (non-shadowed) register block for a multi-group unit.
//               Holds the producer group pointer, exposes the consumer pointer
//               and per-group status, rejects producer writes that target a
//               RUNNING or non-existent group (sticky prod_err), counts writes
//               to the read-only STATUS register and returns registered reads.
//   Register map (byte offsets from BASE_ADDR):
//     +0x0 STATUS  RO  status zero-extended
//     +0x4 POINTER     [PTR_W-1:0] producer RW, [16+:PTR_W] consumer RO,
//                      [30] prod_err W1C, [31] ADVANCE write-only
//     +0x8 ERR_CNT     [7:0] saturating count of STATUS writes, write clears
// Ports       :
//   nvdla_core_clk  in   core clock, rising edge
//   nvdla_core_rst  in   synchronous active-high reset
//   csb             slave modport of nv_nvdla_grp_single_reg_if
//   producer        out  group currently being programmed
//   consumer        in   group currently executing
//   status          in   per-group state, group g at [2g+1:2g]
//   prod_err        out  sticky producer-write rejection flag
// Config macro: NVDLA_GRP_SREG_ADVANCE_EN - POINTER write with bit31 set
//               targets (producer+1) mod NUM_GROUPS instead of the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module nv_nvdla_grp_single_reg #(
   parameter int          NUM_GROUPS = 2,
   parameter int          PTR_W      = 1,
   parameter logic [11:0] BASE_ADDR  = 12'h000
) (
   input  logic                      nvdla_core_clk,
   input  logic                      nvdla_core_rst,
   nv_nvdla_grp_single_reg_if.slave  csb,
   output logic [PTR_W-1:0]          producer,
   input  logic [PTR_W-1:0]          consumer,
   input  logic [2*NUM_GROUPS-1:0]   status,
   output logic                      prod_err
);

   localparam logic [11:0] ADDR_STATUS  = BASE_ADDR;
   localparam logic [11:0] ADDR_POINTER = BASE_ADDR + 12'd4;
   localparam logic [11:0] ADDR_ERR_CNT = BASE_ADDR + 12'd8;
   // Every value the pointer field can encode gets a slot, so the RUNNING
   // lookup below never indexes past the vector even for illegal targets.
   localparam int          SLOTS        = 1 << PTR_W;
   localparam logic [1:0]  ST_RUNNING   = 2'b01;

   logic [7:0]       err_cnt;
   logic             sel_status;
   logic             sel_pointer;
   logic             sel_err_cnt;
   logic [SLOTS-1:0] running;
   logic [PTR_W-1:0] target;
   logic             out_of_range;
   logic             reject;
   logic [31:0]      rd_mux;
   logic             unused_wr_data;

   assign sel_status  = (csb.reg_offset == ADDR_STATUS);
   assign sel_pointer = (csb.reg_offset == ADDR_POINTER);
   assign sel_err_cnt = (csb.reg_offset == ADDR_ERR_CNT);

   // Per-slot RUNNING flags; slots beyond NUM_GROUPS are never running but
   // are rejected by the range check anyway. Encoding 3 counts as not running.
   for (genvar g = 0; g < SLOTS; g++) begin : g_running
      if (g < NUM_GROUPS) begin : g_real
         assign running[g] = (status[2*g +: 2] == ST_RUNNING);
      end else begin : g_pad
         assign running[g] = 1'b0;
      end
   end

`ifdef NVDLA_GRP_SREG_ADVANCE_EN
   localparam logic [PTR_W-1:0] LAST_GROUP = PTR_W'(NUM_GROUPS - 1);
   logic [PTR_W-1:0] next_ptr;

   // Explicit wrap so non power-of-two group counts return to 0.
   assign next_ptr = (producer == LAST_GROUP) ? '0 : producer + 1'b1;
   assign target   = csb.reg_wr_data[31] ? next_ptr : csb.reg_wr_data[PTR_W-1:0];
`else
   assign target   = csb.reg_wr_data[PTR_W-1:0];
`endif

   assign out_of_range = ({{(32-PTR_W){1'b0}}, target} >= 32'(NUM_GROUPS));
   assign reject       = out_of_range | running[target];

   // Data bits with no storage behind them.
   assign unused_wr_data = ^{csb.reg_wr_data[31], csb.reg_wr_data[29:PTR_W]};

   // Read mux from current register state, so a same-cycle write is not
   // visible until the following read.
   always_comb begin
      rd_mux = '0;
      if (sel_status) begin
         rd_mux = 32'(status);
      end else if (sel_pointer) begin
         rd_mux[PTR_W-1:0]  = producer;
         rd_mux[16 +: PTR_W] = consumer;
         rd_mux[30]         = prod_err;
      end else if (sel_err_cnt) begin
         rd_mux[7:0] = err_cnt;
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         producer        <= '0;
         prod_err        <= 1'b0;
         err_cnt         <= '0;
         csb.reg_rd_data <= '0;
         csb.reg_rd_vld  <= 1'b0;
      end else begin
         csb.reg_rd_vld <= csb.reg_rd_en;
         if (csb.reg_rd_en) begin
            csb.reg_rd_data <= rd_mux;
         end

         if (csb.reg_wr_en && sel_pointer) begin
            if (reject) begin
               // Rejection wins over a simultaneous W1C of the flag.
               prod_err <= 1'b1;
            end else begin
               producer <= target;
               if (csb.reg_wr_data[30]) begin
                  prod_err <= 1'b0;
               end
            end
         end

         if (csb.reg_wr_en && sel_err_cnt) begin
            err_cnt <= '0;
         end else if (csb.reg_wr_en && sel_status && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_grp_single_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_nv_nvdla_grp_single_reg
// Description : Scoreboard bench for nv_nvdla_grp_single_reg with three groups
//               (non power-of-two) at a non-zero base address. Stimulus
//               pushes expected read data into a queue from a behavioural
//               model; a monitor pops on reg_rd_vld and also compares the
//               producer pointer and error flag every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_nvdla_grp_single_reg;

   localparam int          NG   = 3;
   localparam int          PW   = 2;
   localparam logic [11:0] BASE = 12'h040;
   localparam logic [11:0] A_ST = BASE;
   localparam logic [11:0] A_PT = BASE + 12'd4;
   localparam logic [11:0] A_EC = BASE + 12'd8;
`ifdef NVDLA_GRP_SREG_ADVANCE_EN
   localparam bit ADV = 1'b1;
`else
   localparam bit ADV = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic            clk;
   logic            rst;
   logic [PW-1:0]   producer;
   logic [PW-1:0]   consumer;
   logic [2*NG-1:0] status;
   logic            prod_err;

   nv_nvdla_grp_single_reg_if bus ();

   nv_nvdla_grp_single_reg #(
      .NUM_GROUPS (NG),
      .PTR_W      (PW),
      .BASE_ADDR  (BASE)
   ) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .csb            (bus),
      .producer       (producer),
      .consumer       (consumer),
      .status         (status),
      .prod_err       (prod_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];
   int          m_prod;
   int          m_err;
   int          m_cnt;
   logic [31:0] last_rd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int grp_state(input logic [2*NG-1:0] st, input int g);
      return int'((st >> (2*g)) & 6'd3);
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] off,
                                              input logic [2*NG-1:0] st,
                                              input logic [PW-1:0] cons);
      if (off == A_ST) return 32'(st);
      if (off == A_PT) return (32'(cons) << 16) | 32'(m_prod) | (32'(m_err) << 30);
      if (off == A_EC) return 32'(m_cnt);
      return 32'd0;
   endfunction

   task automatic model_write(input logic [11:0] off, input logic [31:0] d,
                              input logic [2*NG-1:0] st);
      int t;
      if (off == A_PT) begin
         if (ADV && d[31]) t = (m_prod + 1) % NG;
         else              t = int'(d[PW-1:0]);
         if (t >= NG || grp_state(st, t) == 1) begin
            m_err = 1;
         end else begin
            m_prod = t;
            if (d[30]) m_err = 0;
         end
      end else if (off == A_ST) begin
         if (m_cnt < 255) m_cnt++;
      end else if (off == A_EC) begin
         m_cnt = 0;
      end
   endtask

   task automatic model_reset();
      m_prod = 0;
      m_err  = 0;
      m_cnt  = 0;
   endtask

   // ---------------- stimulus ----------------
   task automatic drive(input bit r, input bit wr, input bit rd, input logic [11:0] off,
                        input logic [31:0] d, input logic [2*NG-1:0] st,
                        input logic [PW-1:0] cons);
      exp_t e;
      @(negedge clk);
      rst             = r;
      bus.reg_wr_en   = wr;
      bus.reg_rd_en   = rd;
      bus.reg_offset  = off;
      bus.reg_wr_data = d;
      status          = st;
      consumer        = cons;
      if (r) begin
         model_reset();
      end else begin
         if (rd) begin
            e.data = model_read(off, st, cons);
            e.due  = cyc + 1;
            q.push_back(e);
         end
         if (wr) model_write(off, d, st);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst) last_rd = '0;
         while (q.size() > 0 && q[0].due < cyc) begin
            check("rd_vld_missing", 32'(bus.reg_rd_vld), 32'd1);
            void'(q.pop_front());
         end
         if (bus.reg_rd_vld) begin
            if (q.size() == 0) begin
               check("rd_vld_spurious", 32'(bus.reg_rd_vld), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("rd_latency", 32'(cyc), 32'(e.due));
               check("rd_data", bus.reg_rd_data, e.data);
               last_rd = e.data;
            end
         end else begin
            check("rd_data_hold", bus.reg_rd_data, last_rd);
         end
         check("producer", 32'(producer), 32'(m_prod));
         check("prod_err", 32'(prod_err), 32'(m_err));
      end
   end

   initial begin
      rst             = 1'b1;
      bus.reg_wr_en   = 1'b0;
      bus.reg_rd_en   = 1'b0;
      bus.reg_offset  = '0;
      bus.reg_wr_data = '0;
      status          = '0;
      consumer        = '0;
      model_reset();

      // Reset for two cycles, then read ERR_CNT.
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, A_EC, 0, 0, 0);

      // Accepted pointer write, then readback with consumer=1.
      drive(0, 1, 0, A_PT, 32'd2, 0, 0);
      drive(0, 0, 1, A_PT, 0, 0, 2'd1);

      // Group 2 RUNNING: reject, then accepted write with W1C.
      drive(0, 1, 0, A_PT, 32'd0, 0, 0);
      drive(0, 1, 0, A_PT, 32'd2, 6'b010000, 0);
      drive(0, 1, 1, A_PT, 32'h4000_0001, 6'b010000, 0);
      drive(0, 0, 1, A_PT, 0, 6'b010000, 0);

      // Out-of-range target, rejected even with W1C set.
      drive(0, 1, 0, A_PT, 32'h4000_0003, 0, 0);
      drive(0, 0, 1, A_PT, 0, 0, 0);

      // Advance wrap from the last group (plain load of 0 without the feature).
      drive(0, 1, 0, A_PT, 32'h4000_0002, 0, 0);
      drive(0, 1, 0, A_PT, 32'h8000_0000, 0, 0);
      drive(0, 1, 0, A_PT, 32'h8000_0001, 6'b000001, 0);
      drive(0, 0, 1, A_PT, 0, 0, 0);

      // ERR_CNT saturation, clear, STATUS readback.
      for (int i = 0; i < 300; i++) drive(0, 1, 0, A_ST, $urandom, 0, 0);
      drive(0, 0, 1, A_EC, 0, 0, 0);
      drive(0, 1, 0, A_EC, 32'h0000_00AA, 0, 0);
      drive(0, 0, 1, A_EC, 0, 0, 0);
      drive(0, 0, 1, A_ST, 0, 6'b001001, 0);

      // Reserved status encoding 3 does not block, same-cycle read/write.
      drive(0, 1, 0, A_PT, 32'd0, 6'b111111, 0);
      drive(0, 1, 1, A_PT, 32'd1, 0, 0);
      drive(0, 0, 1, A_PT, 0, 0, 0);

      // Unmapped offsets: reads 0, writes have no effect.
      drive(0, 1, 1, BASE + 12'd12, 32'hFFFF_FFFF, 0, 0);
      drive(0, 1, 1, 12'h000, 32'hFFFF_FFFF, 0, 0);
      drive(0, 0, 1, A_PT, 0, 0, 0);

      // Read issued in a reset cycle is discarded.
      drive(0, 0, 1, A_PT, 0, 0, 0);
      drive(1, 1, 1, A_PT, 32'd2, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [11:0] off;
         logic [31:0] d;
         case ($urandom_range(0, 5))
            0:       off = A_ST;
            1, 2:    off = A_PT;
            3:       off = A_EC;
            4:       off = BASE + 12'd12;
            default: off = 12'($urandom);
         endcase
         d = $urandom;
         if ($urandom_range(0, 3) != 0) d[29:2] = '0;
         drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, off, d, 6'($urandom), 2'($urandom));
      end

      repeat (4) drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
